// File: rtl/text_scroller_if.sv
// Byte-stream input and 16-character window output of the text scroller.
interface text_scroller_if;
   logic [7:0]   ascii_data;
   logic         ascii_data_ready;
   logic [127:0] string_data;

   modport master (output ascii_data, output ascii_data_ready, input string_data);
   modport slave  (input ascii_data, input ascii_data_ready, output string_data);
endinterface

// File: rtl/text_scroller.sv
// Captures one message per ready burst into a 2048x8 buffer and presents a 16-char window,
// static for short messages, otherwise scrolled with begin/step/end dwell times.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | nothing to do; static message or no message shown
// LOAD       | fetching 16 chars at offset into shadow, then one display update
// BEGIN_WAIT | holding window at offset 0 before scrolling starts
// STEP_WAIT  | holding an intermediate window for one scroll step
// END_WAIT   | holding the final window (offset len-16) before wrapping
module text_scroller #(
   parameter int unsigned SCROLL_SPEED_CNT = 25_000_000,
   parameter int unsigned SCROLL_BEGIN_CNT = 100_000_000,
   parameter int unsigned SCROLL_END_CNT   = 100_000_000
) (
   input  logic           clk,
   input  logic           reset,
   text_scroller_if.slave txt,
   output logic           wr_en_DEBUG,
   output logic [7:0]     wr_data_DEBUG,
   output logic [10:0]    wr_addr_DEBUG,
   output logic           cntr_DEBUG,
   output logic           set_disp_DEBUG,
   output logic [3:0]     rel_pos_DEBUG,
   output logic [10:0]    rd_addr_DEBUG,
   output logic [7:0]     rd_data_DEBUG
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_BEGIN_WAIT, S_STEP_WAIT, S_END_WAIT
   } state_t;

   localparam logic [31:0]  SPEED_TC  = 32'(SCROLL_SPEED_CNT - 1);
   localparam logic [31:0]  BEGIN_TC  = 32'(SCROLL_BEGIN_CNT - 1);
   localparam logic [31:0]  END_TC    = 32'(SCROLL_END_CNT - 1);
   localparam logic [11:0]  MEM_DEPTH = 12'd2048;
   localparam logic [127:0] SPACES    = {16{8'h20}};

   state_t       state, state_nxt;
   logic [7:0]   mem [0:2047];
   logic         ready, burst_end, wr_keep;
   logic [11:0]  byte_cnt, len, pos_sum;
   logic [10:0]  offset;
   logic [4:0]   ld_step;
   logic [31:0]  dwell_cnt;
   logic [127:0] shadow;
   logic         fill_vld, fill_in_range;
   logic [3:0]   fill_idx;
   logic [6:0]   fill_lsb;
   logic         load_go, off_clr, off_inc, len_latch, disp_upd, expire;

   assign ready     = txt.ascii_data_ready;
   assign burst_end = !ready && wr_en_DEBUG;

   // Write side is registered once; the buffer is written from the registered copy.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_en_DEBUG   <= 1'b0;
         wr_data_DEBUG <= 8'h00;
         wr_addr_DEBUG <= 11'd0;
         byte_cnt      <= 12'd0;
         wr_keep       <= 1'b0;
      end else begin
         wr_en_DEBUG <= ready;
         wr_keep     <= 1'b0;
         if (ready) begin
            wr_data_DEBUG <= txt.ascii_data;
            if (!wr_en_DEBUG) begin
               wr_addr_DEBUG <= 11'd0;
               byte_cnt      <= 12'd1;
               wr_keep       <= 1'b1;
            end else if (byte_cnt != MEM_DEPTH) begin
               wr_addr_DEBUG <= wr_addr_DEBUG + 11'd1;
               byte_cnt      <= byte_cnt + 12'd1;
               wr_keep       <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_keep) mem[wr_addr_DEBUG] <= wr_data_DEBUG;
   end

   assign rel_pos_DEBUG = (ld_step < 5'd16) ? ld_step[3:0] : 4'd15;
   assign pos_sum       = {1'b0, offset} + {8'd0, rel_pos_DEBUG};
   assign rd_addr_DEBUG = pos_sum[10:0];
   assign fill_lsb      = {~fill_idx, 3'b000};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load_go   = 1'b0;
      off_clr   = 1'b0;
      off_inc   = 1'b0;
      len_latch = 1'b0;
      disp_upd  = 1'b0;
      expire    = 1'b0;
      if (ready) begin
         state_nxt = state;
      end else if (burst_end) begin
         state_nxt = S_LOAD;
         load_go   = 1'b1;
         off_clr   = 1'b1;
         len_latch = 1'b1;
      end else begin
         case (state)
            S_LOAD: if (ld_step == 5'd17) begin
               disp_upd = 1'b1;
               if (len <= 12'd16)                 state_nxt = S_IDLE;
               else if (offset == 11'd0)          state_nxt = S_BEGIN_WAIT;
               else if ({1'b0, offset} == len - 12'd16) state_nxt = S_END_WAIT;
               else                               state_nxt = S_STEP_WAIT;
            end
            S_BEGIN_WAIT: if (dwell_cnt == BEGIN_TC) begin
               expire = 1'b1; off_inc = 1'b1; load_go = 1'b1; state_nxt = S_LOAD;
            end
            S_STEP_WAIT: if (dwell_cnt == SPEED_TC) begin
               expire = 1'b1; off_inc = 1'b1; load_go = 1'b1; state_nxt = S_LOAD;
            end
            S_END_WAIT: if (dwell_cnt == END_TC) begin
               expire = 1'b1; off_clr = 1'b1; load_go = 1'b1; state_nxt = S_LOAD;
            end
            default: state_nxt = state;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         len            <= 12'd0;
         offset         <= 11'd0;
         dwell_cnt      <= 32'd0;
         ld_step        <= 5'd0;
         rd_data_DEBUG  <= 8'h00;
         fill_vld       <= 1'b0;
         fill_in_range  <= 1'b0;
         fill_idx       <= 4'd0;
         shadow         <= SPACES;
         txt.string_data <= SPACES;
         set_disp_DEBUG <= 1'b0;
         cntr_DEBUG     <= 1'b0;
      end else begin
         set_disp_DEBUG <= disp_upd;
         cntr_DEBUG     <= expire;
         if (len_latch) len <= byte_cnt;
         if (off_clr)      offset <= 11'd0;
         else if (off_inc) offset <= offset + 11'd1;

         if (load_go || state_nxt != state) dwell_cnt <= 32'd0;
         else if (!ready)                   dwell_cnt <= dwell_cnt + 32'd1;

         if (load_go || state_nxt != S_LOAD)  ld_step <= 5'd0;
         else if (!ready && ld_step != 5'd17) ld_step <= ld_step + 5'd1;

         // Read data lands one cycle after the address; the shadow slot is filled the cycle after that.
         fill_vld <= 1'b0;
         if (state == S_LOAD && !ready && ld_step < 5'd16) begin
            rd_data_DEBUG <= mem[rd_addr_DEBUG];
            fill_vld      <= 1'b1;
            fill_idx      <= ld_step[3:0];
            fill_in_range <= pos_sum < len;
         end
         if (fill_vld) shadow[fill_lsb +: 8] <= fill_in_range ? rd_data_DEBUG : 8'h20;
         if (disp_upd) txt.string_data <= shadow;
      end
   end

endmodule

// File: tb/tb_text_scroller.sv
// Directed bench for text_scroller: message table, scroll cadence, abort and reset sequences.
module tb_text_scroller;
   localparam int SPD = 30, BEG = 40, ENDC = 40, LD = 18;

   logic         clk = 1'b0;
   logic         reset;
   logic         wr_en_DEBUG, cntr_DEBUG, set_disp_DEBUG;
   logic [7:0]   wr_data_DEBUG, rd_data_DEBUG;
   logic [10:0]  wr_addr_DEBUG, rd_addr_DEBUG;
   logic [3:0]   rel_pos_DEBUG;

   text_scroller_if txt();

   text_scroller #(.SCROLL_SPEED_CNT(SPD), .SCROLL_BEGIN_CNT(BEG), .SCROLL_END_CNT(ENDC)) dut (
      .clk(clk), .reset(reset), .txt(txt),
      .wr_en_DEBUG(wr_en_DEBUG), .wr_data_DEBUG(wr_data_DEBUG), .wr_addr_DEBUG(wr_addr_DEBUG),
      .cntr_DEBUG(cntr_DEBUG), .set_disp_DEBUG(set_disp_DEBUG), .rel_pos_DEBUG(rel_pos_DEBUG),
      .rd_addr_DEBUG(rd_addr_DEBUG), .rd_data_DEBUG(rd_data_DEBUG)
   );

   always #5 clk = ~clk;

   typedef struct {
      int           n;
      logic [127:0] msg;
      logic [127:0] exp;
   } vec_t;

   localparam logic [127:0] SPACES = {16{8'h20}};

   int         total = 0;
   int         bad = 0;
   logic [7:0] msg_mem [0:2047];
   int         msg_len = 0;
   int         scroll_off = 0;
   vec_t       vecs [4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] window(input int off);
      logic [127:0] w;
      w = '0;
      for (int i = 0; i < 16; i++)
         w[127-8*i -: 8] = (off + i < msg_len) ? msg_mem[off+i] : 8'h20;
      return w;
   endfunction

   task automatic send_burst(input int n);
      logic [7:0] b;
      for (int i = 0; i < n; i++) begin
         b = (i < 2048) ? msg_mem[i] : 8'hAA;
         txt.ascii_data = b;
         txt.ascii_data_ready = 1'b1;
         tick();
         if (i < 40 || i >= n - 2)
            chk("wr_port", 128'({wr_en_DEBUG, wr_addr_DEBUG, wr_data_DEBUG}),
                128'({1'b1, 11'((i < 2047) ? i : 2047), b}));
      end
      txt.ascii_data_ready = 1'b0;
      msg_len = (n < 2048) ? n : 2048;
   endtask

   task automatic wait_disp(input int bound, output int cyc, output int ncntr);
      cyc = 0;
      ncntr = 0;
      do begin
         tick();
         cyc++;
         if (cntr_DEBUG) ncntr++;
      end while (!set_disp_DEBUG && cyc < bound);
      if (!set_disp_DEBUG) begin
         total++;
         bad++;
         $display("FAIL disp_timeout: got no set_disp within %0d cycles", bound);
      end
   endtask

   task automatic check_scroll(input int steps);
      int last, nxt, gap, cyc, nc;
      for (int k = 0; k < steps; k++) begin
         last = msg_len - 16;
         gap  = (scroll_off == 0) ? BEG + LD : (scroll_off == last) ? ENDC + LD : SPD + LD;
         nxt  = (scroll_off == last) ? 0 : scroll_off + 1;
         wait_disp(gap + 10, cyc, nc);
         chk("scroll_gap", 128'(cyc), 128'(gap));
         chk("scroll_cntr", 128'(nc), 128'd1);
         chk("scroll_win", txt.string_data, window(nxt));
         scroll_off = nxt;
      end
   endtask

   task automatic idle_quiet(input int n, input logic [127:0] exp);
      int pulses;
      pulses = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (cntr_DEBUG || set_disp_DEBUG) pulses++;
      end
      chk("static_pulses", 128'(pulses), 128'd0);
      chk("static_hold", txt.string_data, exp);
   endtask

   initial begin
      int cyc, nc, pulses;
      vecs[0] = '{4,  {32'hDEADBEEF, 96'h0}, {32'hDEADBEEF, {12{8'h20}}}};
      vecs[1] = '{1,  {8'h42, 120'h0},       {8'h42, {15{8'h20}}}};
      vecs[2] = '{16, 128'h4142434445464748494A4B4C4D4E4F50, 128'h4142434445464748494A4B4C4D4E4F50};
      vecs[3] = '{3,  {24'h20007F, 104'h0},  {24'h20007F, {13{8'h20}}}};

      reset = 1'b0;
      txt.ascii_data = 8'h00;
      txt.ascii_data_ready = 1'b0;
      repeat (3) tick();
      chk("reset_string", txt.string_data, SPACES);
      chk("reset_debug", 128'({wr_en_DEBUG, wr_data_DEBUG, wr_addr_DEBUG, cntr_DEBUG, set_disp_DEBUG,
                               rel_pos_DEBUG, rd_addr_DEBUG, rd_data_DEBUG}), 128'd0);
      reset = 1'b1;
      repeat (2) tick();
      chk("post_reset_string", txt.string_data, SPACES);

      // 32-byte rising/falling message: full scroll cycle and wrap
      for (int i = 0; i < 16; i++) begin
         msg_mem[i]      = 8'(i * 17);
         msg_mem[16 + i] = 8'((15 - i) * 17);
      end
      send_burst(32);
      wait_disp(40, cyc, nc);
      chk("first_latency", 128'(cyc), 128'd19);
      chk("first_window", txt.string_data, 128'h00112233445566778899AABBCCDDEEFF);
      scroll_off = 0;
      check_scroll(1);
      chk("second_window", txt.string_data, 128'h112233445566778899AABBCCDDEEFFFF);
      check_scroll(15);
      chk("final_window", txt.string_data, 128'hFFEEDDCCBBAA99887766554433221100);
      check_scroll(1);
      chk("wrap_window", txt.string_data, 128'h00112233445566778899AABBCCDDEEFF);

      repeat (2000) tick();

      // Short messages stay static
      for (int v = 0; v < 4; v++) begin
         for (int i = 0; i < vecs[v].n; i++) msg_mem[i] = vecs[v].msg[127-8*i -: 8];
         send_burst(vecs[v].n);
         wait_disp(40, cyc, nc);
         chk("tbl_latency", 128'(cyc), 128'd19);
         chk("tbl_window", txt.string_data, vecs[v].exp);
         idle_quiet(150, vecs[v].exp);
      end

      // New burst one cycle after a burst ends aborts the pending LOAD
      for (int i = 0; i < 4; i++) msg_mem[i] = vecs[0].msg[127-8*i -: 8];
      send_burst(4);
      tick();
      msg_mem[0] = 8'h42;
      send_burst(1);
      chk("abort_hold", txt.string_data, vecs[3].exp);
      wait_disp(40, cyc, nc);
      chk("abort_latency", 128'(cyc), 128'd19);
      chk("abort_window", txt.string_data, {8'h42, {15{8'h20}}});
      idle_quiet(100, {8'h42, {15{8'h20}}});

      // 17 chars: begin dwell then straight to end dwell
      for (int i = 0; i < 17; i++) msg_mem[i] = 8'(i + 1);
      send_burst(17);
      wait_disp(40, cyc, nc);
      chk("len17_latency", 128'(cyc), 128'd19);
      chk("len17_window", txt.string_data, window(0));
      scroll_off = 0;
      check_scroll(3);

      // Writes past 2048 bytes are dropped
      for (int i = 0; i < 2048; i++) msg_mem[i] = 8'(i);
      send_burst(2050);
      wait_disp(40, cyc, nc);
      chk("sat_window", txt.string_data, 128'h000102030405060708090A0B0C0D0E0F);

      // Reset in the middle of LOAD clears the window asynchronously
      send_burst(20);
      repeat (6) tick();
      chk("midload_relpos_nonzero", 128'(rel_pos_DEBUG != 4'd0), 128'd1);
      reset = 1'b0;
      #1;
      chk("midload_reset_string", txt.string_data, SPACES);
      chk("midload_reset_relpos", 128'(rel_pos_DEBUG), 128'd0);
      repeat (3) tick();
      reset = 1'b1;
      pulses = 0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (set_disp_DEBUG || cntr_DEBUG) pulses++;
      end
      chk("after_reset_pulses", 128'(pulses), 128'd0);
      chk("after_reset_string", txt.string_data, SPACES);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
